h264_frame_gate: RTL and testbench

- Conditions the raw 4:2:2 pixel stream into a frame-exact stream for the H.264 I-frame encoder in the `sys_clk_i` domain; sits directly upstream of `h264_top`.
- Samples the encoder enable only at frame boundaries and crops each frame to whole 16x16 macroblocks.
- Pads truncated frames with black so the encoder always sees exactly `hres_o*vres_o` pixels followed by one end-of-frame pulse.
- Drives `frame_valid_i`, `eof_i`, `data_valid_i`, `data_y_i`, `data_c_i`, `hres_i` and `vres_i` of `h264_top`.

---
 rtl/h264_pkg.sv | 18 +
 rtl/h264_xy_counter.sv | 43 ++++
 rtl/h264_frame_gate.sv | 181 ++++++++++++++++++
 tb/tb_h264_frame_gate.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h264_pkg.sv
// Shared definitions for the H.264 front-end: gate FSM states, macroblock
// geometry and the pad colour used for truncated frames.
package h264_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        PAD,
        EOF
    } gate_state_t;

    typedef logic [15:0] res_t;

    localparam int         MB_SIZE       = 16;
    localparam logic [7:0] PAD_Y_DEFAULT = 8'h10;
    localparam logic [7:0] PAD_C_DEFAULT = 8'h80;

endpackage

// File: rtl/h264_xy_counter.sv
// Raster position counter: column wraps at 'width' and bumps the row;
// 'last' flags the final pixel of a width x height raster.
module h264_xy_counter
    import h264_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        advance,
    input  logic [15:0] width,
    input  logic [15:0] height,
    output logic [15:0] col,
    output logic [15:0] row,
    output logic        last
);

    res_t col_max;
    res_t row_max;

    assign col_max = width - 16'd1;
    assign row_max = height - 16'd1;
    assign last    = (col == col_max) && (row == row_max);

    // A clear that coincides with an advance counts that pixel as (0,0), so the
    // counter already points at (1,0); every raster is at least one macroblock wide.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= advance ? 16'd1 : 16'd0;
            row <= '0;
        end else if (advance) begin
            if (col == col_max) begin
                col <= '0;
                row <= row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end
    end

endmodule

// File: rtl/h264_frame_gate.sv
// Frame gate in front of h264_top: samples enable per frame, crops to whole
// macroblocks and pads truncated frames so each frame is exactly hres_o*vres_o.
module h264_frame_gate #(
    parameter logic [7:0] PAD_Y   = h264_pkg::PAD_Y_DEFAULT,
    parameter logic [7:0] PAD_C   = h264_pkg::PAD_C_DEFAULT,
    parameter int         MB_SIZE = h264_pkg::MB_SIZE
) (
    input  logic        sys_clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [15:0] hres_i,
    input  logic [15:0] vres_i,
    input  logic        frame_start_i,
    input  logic        data_valid_i,
    input  logic [7:0]  data_y_i,
    input  logic [7:0]  data_c_i,
    output logic        frame_start_o,
    output logic        eof_o,
    output logic        data_valid_o,
    output logic [7:0]  data_y_o,
    output logic [7:0]  data_c_o,
    output logic [15:0] hres_o,
    output logic [15:0] vres_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] pad_cnt_o,
    output logic [15:0] reject_cnt_o,
    output logic        busy_o
);
    import h264_pkg::*;

    localparam res_t MB_MASK = ~res_t'(MB_SIZE - 1);

    gate_state_t state;
    gate_state_t state_next;

    res_t hin;
    res_t hc;
    res_t vc;
    res_t in_col;
    res_t in_row;
    res_t out_col;
    res_t out_row;
    logic in_last;
    logic out_last;
    logic unused_ok;

    logic accept;
    logic reject;
    logic truncate;
    logic fwd;
    logic pad_emit;
    logic in_adv;

    assign hc = hres_i & MB_MASK;
    assign vc = vres_i & MB_MASK;

    // Only the output raster's last flag and the input column/row are consumed.
    assign unused_ok = &{1'b0, in_last, out_col, out_row};

    h264_xy_counter u_in_pos (
        .clk     (sys_clk_i),
        .reset   (reset_i),
        .clear   (accept),
        .advance (in_adv),
        .width   (hin),
        .height  (vres_o),
        .col     (in_col),
        .row     (in_row),
        .last    (in_last)
    );

    h264_xy_counter u_out_pos (
        .clk     (sys_clk_i),
        .reset   (reset_i),
        .clear   (accept),
        .advance (fwd || pad_emit),
        .width   (hres_o),
        .height  (vres_o),
        .col     (out_col),
        .row     (out_row),
        .last    (out_last)
    );

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        truncate   = 1'b0;
        fwd        = 1'b0;
        pad_emit   = 1'b0;
        in_adv     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start_i && enable_i) begin
                    if (hc == '0 || vc == '0) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        fwd        = data_valid_i;
                        in_adv     = data_valid_i;
                        state_next = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                // A new start mid-frame wins over any coincident pixel: padding begins at once.
                if (frame_start_i) begin
                    truncate   = 1'b1;
                    pad_emit   = 1'b1;
                    state_next = out_last ? EOF : PAD;
                end else begin
                    in_adv = data_valid_i;
                    fwd    = data_valid_i && (in_col < hres_o) && (in_row < vres_o);
                    if (fwd && out_last) begin
                        state_next = EOF;
                    end
                end
            end
            PAD: begin
                pad_emit = 1'b1;
                if (out_last) begin
                    state_next = EOF;
                end
            end
            EOF: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // eof_o trails the EOF state by one edge so it never overlaps the last pixel.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            frame_start_o <= 1'b0;
            eof_o         <= 1'b0;
            data_valid_o  <= 1'b0;
            data_y_o      <= '0;
            data_c_o      <= '0;
            hres_o        <= '0;
            vres_o        <= '0;
            hin           <= '0;
            frame_cnt_o   <= '0;
            pad_cnt_o     <= '0;
            reject_cnt_o  <= '0;
            busy_o        <= 1'b0;
        end else begin
            frame_start_o <= accept;
            eof_o         <= (state == EOF);
            data_valid_o  <= fwd || pad_emit;
            data_y_o      <= pad_emit ? PAD_Y : (fwd ? data_y_i : 8'h00);
            data_c_o      <= pad_emit ? PAD_C : (fwd ? data_c_i : 8'h00);
            busy_o        <= (state_next != IDLE);
            if (accept) begin
                hin    <= hres_i;
                hres_o <= hc;
                vres_o <= vc;
            end
            if (reject) begin
                reject_cnt_o <= reject_cnt_o + 16'd1;
            end
            if (truncate) begin
                pad_cnt_o <= pad_cnt_o + 16'd1;
            end
            if (state == EOF) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_h264_frame_gate.sv
// Bench for h264_frame_gate: a pixel-index reference model checked every cycle,
// plus directed scenarios with hand-computed counts.
module tb_h264_frame_gate;

    logic        sys_clk_i;
    logic        reset_i;
    logic        enable_i;
    logic [15:0] hres_i;
    logic [15:0] vres_i;
    logic        frame_start_i;
    logic        data_valid_i;
    logic [7:0]  data_y_i;
    logic [7:0]  data_c_i;
    logic        frame_start_o;
    logic        eof_o;
    logic        data_valid_o;
    logic [7:0]  data_y_o;
    logic [7:0]  data_c_o;
    logic [15:0] hres_o;
    logic [15:0] vres_o;
    logic [15:0] frame_cnt_o;
    logic [15:0] pad_cnt_o;
    logic [15:0] reject_cnt_o;
    logic        busy_o;

    int checks_total  = 0;
    int checks_passed = 0;
    int dv_seen  = 0;
    int pad_seen = 0;
    int eof_seen = 0;
    int fs_seen  = 0;
    bit compare_on = 1'b0;

    localparam int NEVER = 1 << 30;

    h264_frame_gate dut (
        .sys_clk_i     (sys_clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .hres_i        (hres_i),
        .vres_i        (vres_i),
        .frame_start_i (frame_start_i),
        .data_valid_i  (data_valid_i),
        .data_y_i      (data_y_i),
        .data_c_i      (data_c_i),
        .frame_start_o (frame_start_o),
        .eof_o         (eof_o),
        .data_valid_o  (data_valid_o),
        .data_y_o      (data_y_o),
        .data_c_o      (data_c_o),
        .hres_o        (hres_o),
        .vres_o        (vres_o),
        .frame_cnt_o   (frame_cnt_o),
        .pad_cnt_o     (pad_cnt_o),
        .reject_cnt_o  (reject_cnt_o),
        .busy_o        (busy_o)
    );

    initial sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    // The model tracks a frame as "pixel index n_in arrived, n_out emitted"
    // and derives raster position with division rather than counters.
    typedef struct packed {
        logic        active;
        logic        padding;
        logic        eof_due;
        logic [31:0] hin;
        logic [31:0] hc;
        logic [31:0] vc;
        logic [31:0] n_in;
        logic [31:0] n_out;
        logic [15:0] frames;
        logic [15:0] pads;
        logic [15:0] rejects;
        logic [15:0] hres;
        logic [15:0] vres;
        logic        fs;
        logic        eof;
        logic        dv;
        logic        busy;
        logic [7:0]  y;
        logic [7:0]  c;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t cur, input logic rst, input logic en,
                                          input logic fs, input logic dv,
                                          input logic [15:0] hr, input logic [15:0] vr,
                                          input logic [7:0] y, input logic [7:0] c);
        model_t n;
        logic [31:0] col;
        logic [31:0] row;
        logic [31:0] total;
        n = cur;
        n.fs  = 1'b0;
        n.eof = 1'b0;
        n.dv  = 1'b0;
        n.y   = 8'h00;
        n.c   = 8'h00;
        total = cur.hc * cur.vc;
        if (rst) begin
            n = '0;
        end else if (cur.eof_due) begin
            n.eof     = 1'b1;
            n.frames  = cur.frames + 16'd1;
            n.eof_due = 1'b0;
        end else if (cur.padding || (cur.active && fs)) begin
            if (!cur.padding) n.pads = cur.pads + 16'd1;
            n.active  = 1'b0;
            n.padding = 1'b1;
            n.dv      = 1'b1;
            n.y       = 8'h10;
            n.c       = 8'h80;
            n.n_out   = cur.n_out + 32'd1;
            if (n.n_out == total) begin
                n.padding = 1'b0;
                n.eof_due = 1'b1;
            end
        end else if (cur.active) begin
            if (dv) begin
                col    = cur.n_in % cur.hin;
                row    = cur.n_in / cur.hin;
                n.n_in = cur.n_in + 32'd1;
                if (col < cur.hc && row < cur.vc) begin
                    n.dv    = 1'b1;
                    n.y     = y;
                    n.c     = c;
                    n.n_out = cur.n_out + 32'd1;
                    if (n.n_out == total) begin
                        n.active  = 1'b0;
                        n.eof_due = 1'b1;
                    end
                end
            end
        end else if (fs && en) begin
            if (hr < 16'd16 || vr < 16'd16) begin
                n.rejects = cur.rejects + 16'd1;
            end else begin
                n.active = 1'b1;
                n.hin    = 32'(hr);
                n.hc     = (32'(hr) / 32'd16) * 32'd16;
                n.vc     = (32'(vr) / 32'd16) * 32'd16;
                n.hres   = n.hc[15:0];
                n.vres   = n.vc[15:0];
                n.n_in   = 32'd0;
                n.n_out  = 32'd0;
                n.fs     = 1'b1;
                if (dv) begin
                    n.dv    = 1'b1;
                    n.y     = y;
                    n.c     = c;
                    n.n_in  = 32'd1;
                    n.n_out = 32'd1;
                end
            end
        end
        n.busy = n.active | n.padding | n.eof_due;
        return n;
    endfunction

    initial begin
        m = '0;
        forever begin
            @(posedge sys_clk_i);
            m = model_step(m, reset_i, enable_i, frame_start_i, data_valid_i,
                           hres_i, vres_i, data_y_i, data_c_i);
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] dut_vec();
        logic [127:0] v;
        v = {28'd0, frame_start_o, eof_o, data_valid_o, busy_o, hres_o, vres_o,
             frame_cnt_o, pad_cnt_o, reject_cnt_o,
             data_valid_o ? data_y_o : 8'h00, data_valid_o ? data_c_o : 8'h00};
        return v;
    endfunction

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        v = {28'd0, m.fs, m.eof, m.dv, m.busy, m.hres, m.vres,
             m.frames, m.pads, m.rejects,
             m.dv ? m.y : 8'h00, m.dv ? m.c : 8'h00};
        return v;
    endfunction

    initial begin
        forever begin
            @(negedge sys_clk_i);
            if (compare_on) begin
                checkOutput("cycle_outputs", dut_vec(), model_vec());
            end
            if (data_valid_o) dv_seen++;
            if (data_valid_o && data_y_o == 8'h10 && data_c_o == 8'h80) pad_seen++;
            if (eof_o) eof_seen++;
            if (frame_start_o) fs_seen++;
        end
    end

    task automatic applyStimulus(input logic rst, input logic fs, input logic en, input logic dv,
                                 input logic [15:0] hr, input logic [15:0] vr,
                                 input logic [7:0] y, input logic [7:0] c);
        @(negedge sys_clk_i);
        reset_i       = rst;
        frame_start_i = fs;
        enable_i      = en;
        data_valid_i  = dv;
        hres_i        = hr;
        vres_i        = vr;
        data_y_i      = y;
        data_c_i      = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 16'd0, 16'd0, 8'h00, 8'h00);
    endtask

    // Luma stays at or above 0x80 so real pixels never look like pad pixels.
    function automatic logic [7:0] pix_y(input int i);
        logic [31:0] v;
        v = i;
        return {1'b1, v[6:0]};
    endfunction

    function automatic logic [7:0] pix_c(input int i);
        logic [31:0] v;
        v = i;
        return v[7:0] ^ 8'h5A;
    endfunction

    task automatic run_frame(input int hr, input int vr, input int npix, input bit with_pix,
                             input bit en_start, input int en_drop);
        int p;
        p = with_pix ? 1 : 0;
        applyStimulus(0, 1, en_start, with_pix, 16'(hr), 16'(vr), pix_y(0), pix_c(0));
        for (int k = 0; p < npix; k++) begin
            applyStimulus(0, 0, en_start && (p < en_drop), 1, 16'(hr), 16'(vr), pix_y(p), pix_c(p));
            if (k == 0) checkOutput("start_latency", 128'(frame_start_o), 128'(en_start));
            p++;
        end
    endtask

    initial begin
        int s_dv;
        int s_pad;
        int s_eof;
        int s_fs;

        reset_i = 1'b1; frame_start_i = 1'b0; enable_i = 1'b0; data_valid_i = 1'b0;
        hres_i = '0; vres_i = '0; data_y_i = '0; data_c_i = '0;
        applyStimulus(1, 0, 0, 0, 16'd0, 16'd0, 8'h00, 8'h00);
        applyStimulus(1, 0, 0, 0, 16'd0, 16'd0, 8'h00, 8'h00);
        compare_on = 1'b1;
        idle(2);
        checkOutput("reset_state", {frame_start_o, eof_o, data_valid_o, busy_o, data_y_o, data_c_o,
                    hres_o, vres_o, frame_cnt_o, pad_cnt_o, reject_cnt_o}, 128'd0);

        $display("[TB] full 64x32 frame");
        s_dv = dv_seen; s_eof = eof_seen;
        run_frame(64, 32, 2048, 1, 1, NEVER);
        idle(5);
        checkOutput("full_pixels", 128'(dv_seen - s_dv), 128'd2048);
        checkOutput("full_eof", 128'(eof_seen - s_eof), 128'd1);
        checkOutput("full_frame_cnt", 128'(frame_cnt_o), 128'd1);

        $display("[TB] crop 70x35");
        s_dv = dv_seen;
        run_frame(70, 35, 2450, 0, 1, NEVER);
        checkOutput("crop_hres", 128'(hres_o), 128'd64);
        checkOutput("crop_vres", 128'(vres_o), 128'd32);
        idle(5);
        checkOutput("crop_pixels", 128'(dv_seen - s_dv), 128'd2048);
        checkOutput("crop_frame_cnt", 128'(frame_cnt_o), 128'd2);

        $display("[TB] truncated frame");
        s_dv = dv_seen; s_pad = pad_seen;
        run_frame(64, 32, 1000, 1, 1, NEVER);
        applyStimulus(0, 1, 1, 0, 16'd64, 16'd32, 8'h00, 8'h00);
        for (int i = 0; i < 1100; i++) begin
            if (i == 20) applyStimulus(0, 1, 1, 1, 16'd64, 16'd32, 8'h99, 8'h11);
            else applyStimulus(0, 0, 0, 0, 16'd0, 16'd0, 8'h00, 8'h00);
        end
        checkOutput("trunc_pad_pixels", 128'(pad_seen - s_pad), 128'd1048);
        checkOutput("trunc_pixels", 128'(dv_seen - s_dv), 128'd2048);
        checkOutput("trunc_pad_cnt", 128'(pad_cnt_o), 128'd1);
        checkOutput("trunc_frame_cnt", 128'(frame_cnt_o), 128'd3);
        run_frame(64, 32, 2048, 1, 1, NEVER);
        idle(5);
        checkOutput("after_trunc_frame_cnt", 128'(frame_cnt_o), 128'd4);

        $display("[TB] enable gating");
        s_dv = dv_seen;
        run_frame(64, 32, 200, 1, 0, NEVER);
        checkOutput("disabled_busy", 128'(busy_o), 128'd0);
        idle(3);
        checkOutput("disabled_pixels", 128'(dv_seen - s_dv), 128'd0);
        checkOutput("disabled_frame_cnt", 128'(frame_cnt_o), 128'd4);
        s_dv = dv_seen; s_eof = eof_seen;
        run_frame(64, 32, 2048, 1, 1, 100);
        idle(5);
        checkOutput("enable_drop_pixels", 128'(dv_seen - s_dv), 128'd2048);
        checkOutput("enable_drop_eof", 128'(eof_seen - s_eof), 128'd1);

        $display("[TB] reject and minimum size");
        s_fs = fs_seen;
        applyStimulus(0, 1, 1, 0, 16'd8, 16'd32, 8'h00, 8'h00);
        idle(3);
        applyStimulus(0, 1, 1, 0, 16'd64, 16'd15, 8'h00, 8'h00);
        idle(3);
        applyStimulus(0, 1, 0, 0, 16'd8, 16'd8, 8'h00, 8'h00);
        idle(3);
        checkOutput("reject_cnt", 128'(reject_cnt_o), 128'd2);
        checkOutput("reject_no_start", 128'(fs_seen - s_fs), 128'd0);
        s_dv = dv_seen;
        run_frame(16, 16, 256, 1, 1, NEVER);
        idle(5);
        checkOutput("min_frame_pixels", 128'(dv_seen - s_dv), 128'd256);
        checkOutput("min_frame_cnt", 128'(frame_cnt_o), 128'd6);

        $display("[TB] reset mid-frame");
        s_eof = eof_seen;
        run_frame(64, 32, 500, 1, 1, NEVER);
        applyStimulus(1, 0, 0, 1, 16'd64, 16'd32, 8'h42, 8'h24);
        applyStimulus(0, 0, 0, 0, 16'd0, 16'd0, 8'h00, 8'h00);
        checkOutput("reset_mid_frame", {frame_start_o, eof_o, data_valid_o, busy_o, data_y_o, data_c_o,
                    hres_o, vres_o, frame_cnt_o, pad_cnt_o, reject_cnt_o}, 128'd0);
        idle(10);
        checkOutput("reset_no_eof", 128'(eof_seen - s_eof), 128'd0);
        s_dv = dv_seen;
        run_frame(64, 32, 2048, 1, 1, NEVER);
        idle(5);
        checkOutput("post_reset_pixels", 128'(dv_seen - s_dv), 128'd2048);
        checkOutput("post_reset_frame_cnt", 128'(frame_cnt_o), 128'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
